// File: rtl/int_ctrl.sv
// int_ctrl: bus-slave interrupt controller. It synchronises N_SRC raw interrupt lines
// and latches each source as pending. It drives a registered CPU INT and the cause
// code of the lowest-index pending source that is enabled.
// Ports: clk/rst (async active-high); irq_in[N_SRC-1:0] raw lines; bus slave
//   STB/WE/ADDR/DAT_I in and DAT_O/ACK out (ACK registered, read latency 1);
//   INT/CAUSE out to the CPU, both registered.
// Register map on ADDR[3:2]: 0 PENDING (W1C), 1 MASK, 2 CAUSE (RO), 3 CTRL (bit0 gen).
// Optional build macro INT_CTRL_LEVEL_EN: level-sensitive sources. pending mirrors
//   the synchronised line, and writes to PENDING are ignored.
module int_ctrl #(
  parameter int N_SRC       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d [SYNC_STAGES];
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             gen_q, gen_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_o_q, dat_o_d;
  logic             int_q, int_d;
  logic [31:0]      cause_q, cause_d;

  logic [N_SRC-1:0] sync_out;
  logic [N_SRC-1:0] active;
  logic [31:0]      sel;
  logic [31:0]      rdata;
  logic             wr_en;
  logic [1:0]       reg_sel;
  logic             unused_bits;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign reg_sel  = ADDR[3:2];
  // A write is applied only on the first sampled cycle of a transaction.
  assign wr_en    = STB & WE & ~ack_q;
  assign active   = pending_q & mask_q;
  // Only ADDR[3:2] is decoded, so the register map aliases across the address space.
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I[31:N_SRC]};

  always_comb begin
    sync_d[0] = irq_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

`ifdef INT_CTRL_LEVEL_EN
  // Level mode: pending follows the line, and software clears the source at the device.
  always_comb begin
    pending_d = sync_out;
  end
`else
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;

  assign prev_d = sync_out;
  assign rise   = sync_out & ~prev_q;

  always_comb begin
    w1c = '0;
    if (wr_en && (reg_sel == 2'd0)) begin
      w1c = DAT_I[N_SRC-1:0];
    end
    // A new edge wins over a clear that lands in the same cycle.
    pending_d = (pending_q & ~w1c) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`endif

  always_comb begin
    mask_d = mask_q;
    gen_d  = gen_q;
    if (wr_en && (reg_sel == 2'd1)) begin
      mask_d = DAT_I[N_SRC-1:0];
    end
    if (wr_en && (reg_sel == 2'd3)) begin
      gen_d = DAT_I[0];
    end
  end

  // Lowest index wins. Scan downward so the last hit is the lowest set bit.
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel = 32'(i);
      end
    end
  end

  // CAUSE tracks active even with gen=0, so software can poll it.
  always_comb begin
    int_d   = gen_q & (|active);
    cause_d = (|active) ? sel : 32'd0;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = {{(32-N_SRC){1'b0}}, pending_q};
      2'd1: rdata = {{(32-N_SRC){1'b0}}, mask_q};
      2'd2: rdata = cause_q;
      2'd3: rdata = {31'd0, gen_q};
      default: rdata = '0;
    endcase
  end

  // ACK follows STB by one cycle. Read data is captured as ACK rises and held
  // until STB drops.
  always_comb begin
    ack_d   = STB;
    dat_o_d = '0;
    if (STB && !ack_q) begin
      dat_o_d = rdata;
    end else if (STB && ack_q) begin
      dat_o_d = dat_o_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      pending_q <= '0;
      mask_q    <= '0;
      gen_q     <= 1'b0;
      ack_q     <= 1'b0;
      dat_o_q   <= '0;
      int_q     <= 1'b0;
      cause_q   <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      pending_q <= pending_d;
      mask_q    <= mask_d;
      gen_q     <= gen_d;
      ack_q     <= ack_d;
      dat_o_q   <= dat_o_d;
      int_q     <= int_d;
      cause_q   <= cause_d;
    end
  end

  assign ACK   = ack_q;
  assign DAT_O = dat_o_q;
  assign INT   = int_q;
  assign CAUSE = cause_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed-vector bench for int_ctrl (default edge-latched build).
// Inputs change 1 time unit after the rising edge, and outputs are sampled at the same point.
// It reports each mismatch on a FAIL line and prints one summary line at the end.
module tb_int_ctrl;

  localparam int N_SRC = 6;

  logic             clk;
  logic             rst;
  logic [N_SRC-1:0] irq_in;
  logic             STB;
  logic             WE;
  logic [31:0]      ADDR;
  logic [31:0]      DAT_I;
  logic [31:0]      DAT_O;
  logic             ACK;
  logic             INT;
  logic [31:0]      CAUSE;

  int errors = 0;
  int checks = 0;

  int_ctrl #(.N_SRC(N_SRC), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .STB    (STB),
    .WE     (WE),
    .ADDR   (ADDR),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .ACK    (ACK),
    .INT    (INT),
    .CAUSE  (CAUSE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    STB = 1'b1; WE = 1'b1; ADDR = a; DAT_I = d;
    tick(1);
    chk("wr_ack_hi", {31'd0, ACK}, 32'd1);
    STB = 1'b0; WE = 1'b0;
    tick(1);
    chk("wr_ack_lo", {31'd0, ACK}, 32'd0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    STB = 1'b1; WE = 1'b0; ADDR = a;
    tick(1);
    d = DAT_O;
    STB = 1'b0;
    tick(1);
  endtask

  task automatic pulse_irq(input int idx);
    irq_in[idx] = 1'b1;
    tick(1);
    irq_in[idx] = 1'b0;
  endtask

  logic [31:0] rd;
  int          n;

  initial begin
    rst = 1'b1; irq_in = '0; STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
    tick(3);
    chk("rst_int", {31'd0, INT}, 32'd0);
    chk("rst_cause", CAUSE, 32'd0);
    chk("rst_ack", {31'd0, ACK}, 32'd0);
    chk("rst_dato", DAT_O, 32'd0);
    rst = 1'b0;
    tick(1);

    // All registers read zero after reset.
    for (int r = 0; r < 4; r++) begin
      bus_read(32'(r * 4), rd);
      chk("rst_read", rd, 32'd0);
    end

    // Enable everything. The MASK write goes through an aliased address.
    bus_write(32'h0000_0104, 32'h3F);
    bus_read(32'h4, rd);
    chk("mask_alias", rd, 32'h3F);
    bus_write(32'hC, 32'h1);
    bus_read(32'hC, rd);
    chk("ctrl_rd", rd, 32'h1);

    // One-cycle pulse on source 3. INT must rise within SYNC_STAGES+2 cycles.
    irq_in[3] = 1'b1;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      irq_in[3] = 1'b0;
      if (INT && n == 0) n = k;
    end
    chk("int3_seen", {31'd0, (n >= 1 && n <= 4)}, 32'd1);
    chk("cause3", CAUSE, 32'd3);
    bus_read(32'h0, rd);
    chk("pend08", rd, 32'h08);
    bus_read(32'h8, rd);
    chk("cause_rd", rd, 32'h3);

    // Sources 3 and 4 are pending. Clearing 3 moves CAUSE to 4.
    pulse_irq(4);
    tick(5);
    bus_read(32'h0, rd);
    chk("pend18", rd, 32'h18);
    bus_write(32'h0, 32'h08);
    chk("cause4", CAUSE, 32'd4);
    chk("int_stay", {31'd0, INT}, 32'd1);
    bus_write(32'h8, 32'h0);        // CAUSE is read-only
    chk("cause_ro", CAUSE, 32'd4);
    bus_write(32'h0, 32'h10);
    chk("int_fall", {31'd0, INT}, 32'd0);
    chk("cause0", CAUSE, 32'd0);

    // A W1C that lands in the same cycle as the rising edge on source 1 leaves it set.
    irq_in[1] = 1'b1;
    tick(2);
    bus_write(32'h0, 32'h02);
    bus_read(32'h0, rd);
    chk("w1c_race", rd, 32'h02);
    chk("cause1", CAUSE, 32'd1);
    bus_write(32'h0, 32'h02);
    tick(4);
    bus_read(32'h0, rd);
    chk("held_noreset", rd, 32'h00);
    irq_in[1] = 1'b0;
    tick(3);

    // gen=0 suppresses INT, but CAUSE is still reported.
    bus_write(32'hC, 32'h0);
    pulse_irq(2);
    tick(5);
    chk("gen0_int", {31'd0, INT}, 32'd0);
    chk("gen0_cause", CAUSE, 32'd2);
    bus_write(32'hC, 32'h1);
    chk("gen1_int", {31'd0, INT}, 32'd1);

    // Masking keeps pending but hides the source. Unmasking restores INT.
    bus_write(32'h4, 32'h3B);
    chk("mask_int", {31'd0, INT}, 32'd0);
    chk("mask_cause", CAUSE, 32'd0);
    bus_read(32'h0, rd);
    chk("mask_pend", rd, 32'h04);
    bus_write(32'h4, 32'h3F);
    chk("unmask_int", {31'd0, INT}, 32'd1);
    chk("unmask_cause", CAUSE, 32'd2);
    bus_write(32'h0, 32'h04);
    chk("clr2_int", {31'd0, INT}, 32'd0);

    // Long STB hold: the clear applies once, and a pulse during the hold stays latched.
    pulse_irq(0);
    tick(5);
    chk("src0_int", {31'd0, INT}, 32'd1);
    STB = 1'b1; WE = 1'b1; ADDR = 32'h0; DAT_I = 32'h1;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      chk("hold_ack", {31'd0, ACK}, 32'd1);
      if (c == 1) irq_in[0] = 1'b1;
      if (c == 2) begin
        irq_in[0] = 1'b0;
        chk("hold_clr", {31'd0, INT}, 32'd0);
      end
    end
    chk("hold_reint", {31'd0, INT}, 32'd1);
    STB = 1'b0; WE = 1'b0;
    tick(1);
    chk("hold_ack_lo", {31'd0, ACK}, 32'd0);
    bus_read(32'h0, rd);
    chk("hold_pend", rd, 32'h01);

    // Reset during a held STB drops ACK at once, without waiting for a clock edge.
    STB = 1'b1; WE = 1'b0; ADDR = 32'h4;
    tick(1);
    chk("pre_rst_ack", {31'd0, ACK}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_ack", {31'd0, ACK}, 32'd0);
    chk("async_int", {31'd0, INT}, 32'd0);
    chk("async_dato", DAT_O, 32'd0);
    STB = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    bus_read(32'h4, rd);
    chk("post_rst_mask", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Wishbone-slave interrupt controller between the peripheral interrupt lines (Ram, Disk, VRam, Keyboard, Counter, Switch) and the multi-cycle CPU's INT/Cause_in inputs. It synchronises and edge-detects each source and latches it as pending. Each source can be masked. The controller drives one registered CPU interrupt plus a cause code for the highest-priority enabled pending source. Software reads and clears state through one bus slot.

Parameters:
N_SRC, 6, number of interrupt sources (1..16); source index is the cause code.
SYNC_STAGES, 2, synchroniser flops per irq input (>=2).

Ports:
clk  in  1  system clock (clk100 domain)
rst  in  1  asynchronous, active-high reset
irq_in  in  N_SRC  raw interrupt lines; bit i = source i
STB  in  1  bus strobe for this slave
WE  in  1  bus write enable (valid with STB)
ADDR  in  32  bus address; only ADDR[3:2] decoded
DAT_I  in  32  bus write data
DAT_O  out  32  bus read data
ACK  out  1  bus acknowledge
INT  out  1  CPU interrupt request
CAUSE  out  32  cause code of INT (zero-extended source index)

Behaviour:
- Reset (async, rst=1): pending=0, mask=0, gen=0, all sync/edge flops=0, INT=0, CAUSE=0, ACK=0, DAT_O=0.
- Input path: each irq_in[i] passes through a SYNC_STAGES-flop synchroniser and then one edge-history flop. A rise (sync=1, prev=0) sets pending[i] on that clock. A held-high line sets pending only once per rising edge.
- Register map (ADDR[3:2]):
  - 0 PENDING: read pending, zero-extended. Write-1-to-clear bits [N_SRC-1:0].
  - 1 MASK: read/write. 1 = source enabled.
  - 2 CAUSE: read-only, current CAUSE. Writes are ignored.
  - 3 CTRL: bit0 = gen (global enable), read/write. Other bits read 0.
- Bus handshake:
  - ACK is registered. ACK=1 on the cycle after STB is sampled 1 and stays 1 while STB=1. ACK=0 on the cycle after STB is sampled 0.
  - Read latency is 1 cycle. DAT_O is loaded on the cycle ACK rises and holds while ACK=1.
  - A write takes effect exactly once per transaction, on the clock where STB=1 and ACK=0. A long-held STB does not re-apply it.
  - DAT_O returns 0 when not acknowledging.
- Priority: the lowest index wins. active = pending & mask. sel = index of the lowest set bit of active.
- Outputs (registered, 1 cycle after active changes):
  - INT = gen & |active.
  - CAUSE = sel when |active, else 0.
  - CAUSE updates even when gen=0, so software can poll it.
- Boundary conditions:
  - A W1C and a new rising edge on the same bit in the same cycle: the set wins, so pending stays 1.
  - Masking a pending source removes it from INT/CAUSE but keeps pending. Unmasking it re-raises INT one cycle later.
  - Clearing the selected source while another source is active: CAUSE moves to the next lowest index one cycle later, and INT stays high.
  - All pending cleared: INT falls one cycle after the write.
  - Reset asserted mid-transaction: ACK drops immediately (async) and the write is lost. After reset release, the bus needs a fresh STB.
  - ADDR bits other than [3:2] are ignored, so the map aliases.

Optional Feature:
INT_CTRL_LEVEL_EN. When defined, sources are level-sensitive:
- pending[i] mirrors the synchronised irq_in[i] every cycle.
- The edge-history flops are omitted.
- W1C writes to PENDING are ignored; software clears the source at the device.
When not defined, sources use the edge-latched W1C behaviour described above.

Test Plan:
- Reset, then read all 4 addresses -> DAT_O=0 for each; INT=0; CAUSE=0.
- MASK=0x3F, CTRL=1, pulse irq_in[3] for 1 cycle -> PENDING reads 0x08; INT=1 within SYNC_STAGES+2 cycles; CAUSE=3.
- With PENDING=0x18 (sources 3 and 4), write PENDING=0x08 -> next cycle CAUSE=4 and INT stays 1. Then write 0x10 -> INT=0 and CAUSE=0.
- Hold irq_in[1]=1 while writing PENDING=0x02 in the same cycle as its rising edge is detected -> pending[1] stays 1. Continued high level causes no re-set after a later clear.
- CTRL=0 with source 2 pending and masked in -> INT=0 and CAUSE=2. Write CTRL=1 -> INT=1 next cycle.
- Hold STB=1/WE=1 for 5 cycles writing PENDING=0x01 while irq_in[0] pulses again mid-hold -> ACK rises after 1 cycle and the clear applies once, so pending[0]=1 after the second pulse. Assert rst during a held STB -> ACK=0 immediately.
